// File: rtl/cmd_seq_driver.sv
// cmd_seq_driver: FIFO-buffered UART command sequencer with blocking/fire-and-forget issue and timeout.
// Optional rider-lean step generator included when LEAN_RAMP_EN is defined.
module cmd_seq_driver #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int GAP_W = 16,
  parameter int TMO_CYC = 60000
`ifdef LEAN_RAMP_EN
  , parameter int LEAN_W = 16
`endif
) (
  input  logic                      clk,
  input  logic                      RST_n,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      start,
  input  logic                      blocking,
  input  logic [GAP_W-1:0]          gap_cycles,
  output logic                      trmt,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      err,
  output logic                      ovf,
  input  logic                      clr_err
`ifdef LEAN_RAMP_EN
  , input  logic                    lean_go,
  input  logic signed [LEAN_W-1:0]  lean_target,
  input  logic [GAP_W-1:0]          hold_cycles,
  output logic signed [LEAN_W-1:0]  rider_lean,
  output logic                      lean_busy
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic push, pop, tmo, done;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push  = wr_en && !full;
  assign pop   = state == ISSUE;
  assign trmt  = state == ISSUE;
  assign busy  = state != IDLE;
  assign tmo   = state == WAIT_DONE && tmo_cnt == TW'(TMO_CYC - 1);
  assign done  = tx_done || tmo;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = (start && !empty) ? ISSUE : IDLE;
      ISSUE:     state_nx = blocking ? WAIT_DONE : (gap_cycles != '0 ? GAP : IDLE);
      WAIT_DONE: state_nx = done ? (gap_cycles != '0 ? GAP : IDLE) : WAIT_DONE;
      default:   state_nx = gap_cnt <= GAP_W'(1) ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_data <= '0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + CW'(push) - CW'(pop);
      // head is latched on the way into ISSUE so tx_data is valid alongside trmt
      if (state == IDLE && state_nx == ISSUE) tx_data <= mem[rd_ptr];
      gap_cnt <= (state != GAP && state_nx == GAP) ? gap_cycles : gap_cnt - GAP_W'(state == GAP);
      tmo_cnt <= state == WAIT_DONE ? tmo_cnt + TW'(1) : '0;
      err     <= tmo || (err && !clr_err);
      ovf     <= (wr_en && full) || (ovf && !clr_err);
    end
  end
`ifdef LEAN_RAMP_EN
  logic [GAP_W-1:0] hold_cnt;
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      rider_lean <= '0;
      lean_busy  <= 1'b0;
      hold_cnt   <= '0;
    end else if (!lean_busy) begin
      if (lean_go) begin
        rider_lean <= lean_target;
        lean_busy  <= 1'b1;
        hold_cnt   <= hold_cycles;
      end
    end else if (hold_cnt <= GAP_W'(1)) begin
      rider_lean <= '0;
      lean_busy  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt - GAP_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_cmd_seq_driver.sv
// tb_cmd_seq_driver: scoreboard bench; stimulus queues expected bytes, a monitor checks each trmt.
module tb_cmd_seq_driver;
  localparam int DEPTH = 8;
  localparam int TMO = 200;
  logic clk = 0, RST_n = 0, wr_en = 0, start = 0, blocking = 0, tx_done = 0, clr_err = 0;
  logic [7:0] wr_data = 0, tx_data;
  logic [15:0] gap_cycles = 0;
  logic full, empty, trmt, busy, err, ovf;
  logic [3:0] count;
`ifdef LEAN_RAMP_EN
  logic lean_go = 0, lean_busy;
  logic signed [15:0] lean_target = 0, rider_lean;
  logic [15:0] hold_cycles = 0;
`endif
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int tq[$];
  logic prev_trmt = 0;

  cmd_seq_driver #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
    .clk(clk), .RST_n(RST_n), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .count(count), .start(start), .blocking(blocking), .gap_cycles(gap_cycles), .trmt(trmt),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .err(err), .ovf(ovf), .clr_err(clr_err)
`ifdef LEAN_RAMP_EN
    , .lean_go(lean_go), .lean_target(lean_target), .hold_cycles(hold_cycles),
    .rider_lean(rider_lean), .lean_busy(lean_busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RST_n && trmt) begin
      chk("trmt_width", {31'b0, prev_trmt}, 0);
      if (exp_q.size() == 0) chk("unexpected_tx", {24'b0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      tq.push_back(cyc);
    end
    prev_trmt = RST_n && trmt;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_b(input logic [7:0] d, input bit sent);
    wr_en = 1;
    wr_data = d;
    if (sent) exp_q.push_back(d);
    step();
    wr_en = 0;
  endtask

  task automatic wait_tq(input string name, input int n, input int lim);
    for (int i = 0; i < lim && tq.size() < n; i++) step();
    chk(name, tq.size(), n);
  endtask

  task automatic wait_idle(input string name, input int lim);
    for (int i = 0; i < lim && busy; i++) step();
    chk(name, {31'b0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, lows, hits;
    step();
    wr_en = 1;
    wr_data = 8'hAA;
    repeat (10) step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ovf", {err, ovf}, 0);
    chk("rst_tx_data", tx_data, 0);
`ifdef LEAN_RAMP_EN
    chk("rst_lean", {rider_lean, 15'b0, lean_busy}, 0);
`endif
    wr_en = 0;
    RST_n = 1;
    step();
    // non-blocking burst, gap 4
    gap_cycles = 4;
    push_b(8'h06, 1);
    push_b(8'h0A, 1);
    push_b(8'h3C, 1);
    chk("burst_count", count, 3);
    c0 = cyc;
    start = 1;
    wait_tq("burst_n", 3, 40);
    if (tq.size() == 3) begin
      chk("burst_latency", tq[0] - c0, 1);
      chk("burst_space1", tq[1] - tq[0], 6);
      chk("burst_space2", tq[2] - tq[1], 6);
    end
    step();
    chk("burst_empty", empty, 1);
    wait_idle("burst_idle", 10);
    start = 0;
    tq.delete();
    // blocking, tx_done 100 cycles after trmt
    blocking = 1;
    gap_cycles = 0;
    push_b(8'h47, 1);
    start = 1;
    wait_tq("blk_n", 1, 10);
    lows = 0;
    repeat (99) begin
      step();
      if (!busy) lows++;
    end
    chk("blk_busy_hold", lows, 0);
    tx_done = 1;
    chk("blk_busy_done", busy, 1);
    step();
    tx_done = 0;
    chk("blk_idle", busy, 0);
    chk("blk_err", err, 0);
    start = 0;
    tq.delete();
    // timeout, then continue to next byte; set wins over clear
    push_b(8'h55, 1);
    push_b(8'h66, 1);
    start = 1;
    wait_tq("tmo_n1", 1, 10);
    repeat (TMO) step();
    chk("tmo_err_pre", err, 0);
    chk("tmo_busy_pre", busy, 1);
    step();
    chk("tmo_err_set", err, 1);
    wait_tq("tmo_next", 2, 5);
    repeat (TMO) step();
    clr_err = 1;
    step();
    clr_err = 0;
    chk("tmo_set_wins", err, 1);
    clr_err = 1;
    step();
    clr_err = 0;
    chk("tmo_clr", err, 0);
    start = 0;
    blocking = 0;
    wait_idle("tmo_idle", 5);
    tq.delete();
    // fill, overflow, drain; pointers wrap across both fills
    for (int i = 0; i < DEPTH; i++) push_b(8'h10 + 8'(i), 1);
    chk("fill_full", full, 1);
    chk("fill_count", count, DEPTH);
    chk("fill_ovf_pre", ovf, 0);
    push_b(8'hEE, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, DEPTH);
    start = 1;
    wait_tq("drain_n", DEPTH, 40);
    repeat (6) step();
    chk("drain_no_extra", tq.size(), DEPTH);
    chk("drain_empty", empty, 1);
    start = 0;
    clr_err = 1;
    step();
    clr_err = 0;
    chk("ovf_clr", ovf, 0);
    tq.delete();
    for (int i = 0; i < DEPTH; i++) push_b(8'h80 + 8'(i), 1);
    chk("fill2_full", full, 1);
    start = 1;
    wait_tq("drain2_n", DEPTH, 40);
    wait_idle("drain2_idle", 5);
    chk("drain2_empty", empty, 1);
    start = 0;
`ifdef LEAN_RAMP_EN
    lean_target = 16'sh0FFF;
    hold_cycles = 20;
    lean_go = 1;
    step();
    lean_go = 0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (lean_busy && rider_lean == 16'sh0FFF) hits++;
      lean_go = (i == 5);
      lean_target = (i == 5) ? 16'sh1234 : 16'sh0FFF;
      step();
    end
    lean_go = 0;
    chk("lean_hold", hits, 20);
    chk("lean_end", {rider_lean, 15'b0, lean_busy}, 0);
`else
    hits = 0;
`endif
    chk("sb_drained", exp_q.size(), hits - hits);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
